imem_fetch_controller: RTL and testbench

- Sequences the core's combinational 128-word instruction memory.
- Owns the fetch PC and drives the memory word address; the memory returns read data in the same cycle.
- Buffers fetched {pc, instruction} pairs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, and stops fetching cleanly at misaligned or out-of-range addresses instead of executing past the loaded program.

---
 rtl/imem_fetch_controller.sv | 159 +++++++++++++++
 tb/tb_imem_fetch_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: PC, imem address, prefetch FIFO to decode.
// Halts with a sticky fault on misaligned or out-of-range fetch addresses.
module imem_fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_fpc [FIFO_DEPTH];
  logic [31:0]   r_fin [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_fault;
  logic [31:0]   r_fault_pc;

  logic w_pc_bad;
  logic w_rd_bad;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_set_fault;
  logic w_clr_fault;
  logic w_upd_fpc;

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction

  assign w_pc_bad  = is_bad(r_pc);
  assign w_rd_bad  = is_bad(redirect_pc);
  assign w_full    = (r_cnt == FULL);
  assign out_valid = (r_cnt != '0);
  // A redirect cancels any pop in flight; the flush wins.
  assign w_pop     = out_valid && out_ready && !redirect_valid;

  assign imem_addr = r_pc;
  assign out_instr = r_fin[r_rd];
  assign out_pc    = r_fpc[r_rd];
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and fetch/fault control decode.
  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_set_fault = 1'b0;
    w_clr_fault = 1'b0;
    w_upd_fpc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (fetch_en) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          w_next = fetch_en ? S_FETCH : S_IDLE;
        end else if (w_pc_bad) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
        end else if (!fetch_en) begin
          w_next = S_IDLE;
        end else begin
          w_push = !w_full || w_pop;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          if (w_rd_bad) begin
            w_upd_fpc = 1'b1;
          end else begin
            w_next      = S_FETCH;
            w_clr_fault = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // PC, prefetch FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fpc[i] <= '0;
        r_fin[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_pc  <= redirect_pc;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fpc[r_wr] <= r_pc;
        r_fin[r_wr] <= imem_rdata;
        r_wr        <= r_wr + PW'(1);
        r_pc        <= r_pc + 32'd4;
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Sticky fault flag and offending address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_set_fault) begin
      r_fault    <= 1'b1;
      r_fault_pc <= r_pc;
    end else if (w_clr_fault) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_upd_fpc) begin
      r_fault_pc <= redirect_pc;
    end
  end

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller.
// Vector table for streaming cases, inline sequences for fault/reset.
module tb_imem_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [128];

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a < 32'd512) return mem[a[8:2]];
    return 32'h0;
  endfunction

  always_comb imem_rdata = memword(imem_addr);

  imem_fetch_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  typedef struct {
    bit          rst;
    bit          fen;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ov;
    logic [31:0] opc;
    logic [31:0] addr;
    bit          flt;
    logic [31:0] fpc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    bit rst, bit fen, bit rdy, bit rv, logic [31:0] rpc,
    bit ov, logic [31:0] opc, logic [31:0] addr,
    bit flt, logic [31:0] fpc);
    vec_t v;
    v.rst = rst; v.fen = fen; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ov = ov; v.opc = opc; v.addr = addr; v.flt = flt; v.fpc = fpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit fen, input bit rdy,
                     input bit rv, input logic [31:0] rpc);
    rst_n          = rst;
    fetch_en       = fen;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string nm, input bit was_rst,
                          input bit ov, input logic [31:0] opc,
                          input logic [31:0] addr, input bit flt,
                          input logic [31:0] fpc);
    chk({nm, ".valid"}, 32'(out_valid), 32'(ov));
    chk({nm, ".addr"}, imem_addr, addr);
    chk({nm, ".fault"}, 32'(fault), 32'(flt));
    chk({nm, ".fault_pc"}, fault_pc, fpc);
    if (ov) begin
      chk({nm, ".pc"}, out_pc, opc);
      chk({nm, ".instr"}, out_instr, memword(opc));
    end else if (was_rst) begin
      chk({nm, ".pc"}, out_pc, 32'h0);
      chk({nm, ".instr"}, out_instr, 32'h0);
    end
  endtask

  task automatic step(input string nm, input bit rst, input bit fen,
                      input bit rdy, input bit rv, input logic [31:0] rpc,
                      input bit ov, input logic [31:0] opc,
                      input logic [31:0] addr, input bit flt,
                      input logic [31:0] fpc);
    cyc(rst, fen, rdy, rv, rpc);
    expect_o(nm, !rst, ov, opc, addr, flt, fpc);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;

    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // basic streaming, first word one cycle after entering FETCH
    tv.push_back(mk(0,0,0,0,0,     0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,     0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,0,4,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,4,8,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,8,12,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,12,16,0,0));
    // fetch_en low: go idle, keep and drain FIFO, pc held
    tv.push_back(mk(1,0,0,0,0,     1,12,16,0,0));
    tv.push_back(mk(1,0,1,0,0,     0,0,16,0,0));
    tv.push_back(mk(1,1,1,0,0,     0,0,16,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,16,20,0,0));
    // backpressure: ready low for five cycles from start
    tv.push_back(mk(0,0,0,0,0,     0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,0,     0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,0,     1,0,4,0,0));
    tv.push_back(mk(1,1,0,0,0,     1,0,8,0,0));
    tv.push_back(mk(1,1,0,0,0,     1,0,8,0,0));
    tv.push_back(mk(1,1,0,0,0,     1,0,8,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,4,12,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,8,16,0,0));
    // redirect during an active pop
    tv.push_back(mk(1,1,1,1,32'h40, 0,0,32'h40,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,32'h40,32'h44,0,0));
    tv.push_back(mk(1,1,1,0,0,     1,32'h44,32'h48,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      step($sformatf("v%0d", i), tv[i].rst, tv[i].fen, tv[i].rdy,
           tv[i].rv, tv[i].rpc, tv[i].ov, tv[i].opc, tv[i].addr,
           tv[i].flt, tv[i].fpc);
    end

    // end of memory: 0x200 never pushed, older entries drain
    step("end0", 1,1,1,1,32'h1F8, 0,0,32'h1F8,0,0);
    step("end1", 1,1,1,0,0, 1,32'h1F8,32'h1FC,0,0);
    step("end2", 1,1,0,0,0, 1,32'h1F8,32'h200,0,0);
    step("end3", 1,1,0,0,0, 1,32'h1F8,32'h200,1,32'h200);
    step("end4", 1,1,1,0,0, 1,32'h1FC,32'h200,1,32'h200);
    step("end5", 1,1,1,0,0, 0,0,32'h200,1,32'h200);
    step("end6", 1,1,1,0,0, 0,0,32'h200,1,32'h200);
    step("end7", 1,1,1,1,32'h10, 0,0,32'h10,0,0);
    step("end8", 1,1,1,0,0, 1,32'h10,32'h14,0,0);
    step("end9", 1,1,1,0,0, 1,32'h14,32'h18,0,0);

    // misaligned redirect, bad redirect in HALT, then mid-run reset
    step("mis0", 1,1,1,1,32'h6, 0,0,32'h6,0,0);
    step("mis1", 1,1,1,0,0, 0,0,32'h6,1,32'h6);
    step("mis2", 1,1,1,0,0, 0,0,32'h6,1,32'h6);
    step("mis3", 1,1,1,1,32'h300, 0,0,32'h300,1,32'h300);
    step("mis4", 1,1,0,1,32'h20, 0,0,32'h20,0,0);
    step("mis5", 1,1,0,0,0, 1,32'h20,32'h24,0,0);
    step("mis6", 1,1,0,0,0, 1,32'h20,32'h28,0,0);
    step("rst0", 0,1,0,0,0, 0,0,0,0,0);
    step("rst1", 1,0,1,0,0, 0,0,0,0,0);
    step("rst2", 1,1,1,0,0, 0,0,0,0,0);
    step("rst3", 1,1,1,0,0, 1,0,4,0,0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
